// File: rtl/am_trainer.sv
// am_trainer: training-side prototype builder for the associative memory.
// Per-class per-bit popcounts; majority prototypes streamed out on finalize.
module am_trainer #(
    parameter int HV_DIMENSION = 2000,
    parameter int CLASSES      = 2,
    parameter int LABEL_WIDTH  = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
    input  logic                    Clear_SI,
    input  logic                    Finalize_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] ClassHypervectorOut_DO,
    output logic [LABEL_WIDTH-1:0]  ClassLabelOut_DO,
    output logic                    Drop_SO
);

    localparam int CW = (CLASSES > 1) ? $clog2(CLASSES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMPUTE,
        EMIT
    } state_t;

    state_t                  State_SP;
    logic [CNT_WIDTH-1:0]    BitCnt_DP [CLASSES][HV_DIMENSION];
    logic [CNT_WIDTH-1:0]    SampleCnt_DP [CLASSES];
    logic [0:HV_DIMENSION-1] Hv_DP;
    logic [CW-1:0]           Cls_DP;
    logic [CW-1:0]           ClassIdx_DP;
    logic [CW-1:0]           InCls_D;
    logic                    InBad_D;

    assign InCls_D = LabelIn_DI[CW-1:0];

    // Drop is decided at capture so the pulse lands in the ACCUM cycle.
    assign InBad_D = (int'(LabelIn_DI) >= CLASSES)
                   || (SampleCnt_DP[InCls_D] == '1);

    assign ReadyOut_SO = Reset_RI & (State_SP == IDLE)
                       & ~Clear_SI & ~Finalize_SI;

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            State_SP               <= IDLE;
            BitCnt_DP              <= '{default: '0};
            SampleCnt_DP           <= '{default: '0};
            Hv_DP                  <= '0;
            Cls_DP                 <= '0;
            ClassIdx_DP            <= '0;
            ClassHypervectorOut_DO <= '0;
            ClassLabelOut_DO       <= '0;
            ValidOut_SO            <= 1'b0;
            Drop_SO                <= 1'b0;
        end else begin
            Drop_SO <= 1'b0;
            unique case (State_SP)
                IDLE: begin
                    if (Clear_SI) begin
                        BitCnt_DP    <= '{default: '0};
                        SampleCnt_DP <= '{default: '0};
                    end else if (Finalize_SI) begin
                        ClassIdx_DP <= '0;
                        State_SP    <= COMPUTE;
                    end else if (ValidIn_SI) begin
                        Hv_DP    <= HypervectorIn_DI;
                        Cls_DP   <= InCls_D;
                        Drop_SO  <= InBad_D;
                        State_SP <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!Drop_SO) begin
                        for (int j = 0; j < HV_DIMENSION; j++) begin
                            BitCnt_DP[Cls_DP][j] <= BitCnt_DP[Cls_DP][j]
                                                  + CNT_WIDTH'(Hv_DP[j]);
                        end
                        SampleCnt_DP[Cls_DP] <= SampleCnt_DP[Cls_DP]
                                              + CNT_WIDTH'(1);
                    end
                    State_SP <= IDLE;
                end
                COMPUTE: begin
                    for (int j = 0; j < HV_DIMENSION; j++) begin
                        ClassHypervectorOut_DO[j] <=
                            {BitCnt_DP[ClassIdx_DP][j], 1'b0}
                            > {1'b0, SampleCnt_DP[ClassIdx_DP]};
                    end
                    ClassLabelOut_DO <= LABEL_WIDTH'(ClassIdx_DP);
                    ValidOut_SO      <= 1'b1;
                    State_SP         <= EMIT;
                end
                EMIT: begin
                    if (ReadyIn_SI) begin
                        ValidOut_SO <= 1'b0;
                        if (ClassIdx_DP == LAST) begin
                            State_SP <= IDLE;
                        end else begin
                            ClassIdx_DP <= ClassIdx_DP + CW'(1);
                            State_SP    <= COMPUTE;
                        end
                    end
                end
                default: State_SP <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am_trainer.sv
// tb_am_trainer: randomized bench for am_trainer (8-bit and 2-bit counters).
// Reference keeps the accepted samples and takes majorities directly.
module tb_am_trainer;

    logic       Clk_CI = 1'b0;
    logic       Reset_RI = 1'b0;
    logic       ValidIn = 1'b0;
    logic [0:7] Hv = '0;
    logic [1:0] Label = '0;
    logic       Clear = 1'b0;
    logic       Fin = 1'b0;
    logic       ReadyIn = 1'b0;

    logic       rdy8, vld8, drp8, rdy2, vld2, drp2;
    logic [0:7] hvo8, hvo2;
    logic [1:0] lbo8, lbo2;

    always #5 Clk_CI = ~Clk_CI;

    am_trainer #(
        .HV_DIMENSION(8), .CLASSES(2),
        .LABEL_WIDTH(2), .CNT_WIDTH(8)
    ) dut (
        .Clk_CI(Clk_CI), .Reset_RI(Reset_RI),
        .ValidIn_SI(ValidIn), .ReadyOut_SO(rdy8),
        .HypervectorIn_DI(Hv), .LabelIn_DI(Label),
        .Clear_SI(Clear), .Finalize_SI(Fin),
        .ValidOut_SO(vld8), .ReadyIn_SI(ReadyIn),
        .ClassHypervectorOut_DO(hvo8),
        .ClassLabelOut_DO(lbo8), .Drop_SO(drp8)
    );

    am_trainer #(
        .HV_DIMENSION(8), .CLASSES(2),
        .LABEL_WIDTH(2), .CNT_WIDTH(2)
    ) dut2 (
        .Clk_CI(Clk_CI), .Reset_RI(Reset_RI),
        .ValidIn_SI(ValidIn), .ReadyOut_SO(rdy2),
        .HypervectorIn_DI(Hv), .LabelIn_DI(Label),
        .Clear_SI(Clear), .Finalize_SI(Fin),
        .ValidOut_SO(vld2), .ReadyIn_SI(ReadyIn),
        .ClassHypervectorOut_DO(hvo2),
        .ClassLabelOut_DO(lbo2), .Drop_SO(drp2)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk = 1'b0;

    // Per-cycle expectations sampled by the compare process.
    logic       e_ready, e_valid, e_drop8, e_drop2;
    logic [0:7] e_hv8, e_hv2;
    logic [1:0] e_lbl;

    // Reference: accepted samples, index = width*2 + class.
    logic [0:7] hist [4][256];
    int         cnt [4];
    logic [0:7] em8 [2];
    logic [0:7] em2 [2];

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [0:7] maj(input int i);
        logic [0:7] r;
        int ones;
        for (int j = 0; j < 8; j++) begin
            ones = 0;
            for (int k = 0; k < cnt[i]; k++) ones += int'(hist[i][k][j]);
            r[j] = (2 * ones > cnt[i]);
        end
        return r;
    endfunction

    always @(negedge Clk_CI) begin
        if (chk && Reset_RI) begin
            check("ready8", 32'(rdy8), 32'(e_ready));
            check("ready2", 32'(rdy2), 32'(e_ready));
            check("valid8", 32'(vld8), 32'(e_valid));
            check("valid2", 32'(vld2), 32'(e_valid));
            check("drop8", 32'(drp8), 32'(e_drop8));
            check("drop2", 32'(drp2), 32'(e_drop2));
            if (e_valid) begin
                check("proto8", 32'(hvo8), 32'(e_hv8));
                check("proto2", 32'(hvo2), 32'(e_hv2));
                check("label8", 32'(lbo8), 32'(e_lbl));
                check("label2", 32'(lbo2), 32'(e_lbl));
            end
        end
    end

    task automatic step();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic quiet();
        ValidIn = 1'b0; Clear = 1'b0; Fin = 1'b0;
        e_ready = 1'b1; e_valid = 1'b0;
        e_drop8 = 1'b0; e_drop2 = 1'b0;
    endtask

    task automatic idle(input int k);
        quiet();
        repeat (k) begin
            ReadyIn = 1'($urandom);
            step();
        end
    endtask

    task automatic send(input logic [0:7] v, input logic [1:0] l);
        bit d8, d2;
        quiet();
        ValidIn = 1'b1; Hv = v; Label = l;
        ReadyIn = 1'($urandom);
        step();
        d8 = 1'b1; d2 = 1'b1;
        if (l < 2) begin
            d8 = (cnt[l] == 255);
            d2 = (cnt[2 + l] == 3);
        end
        // Busy cycle: garbage and requests must be ignored.
        ValidIn = 1'($urandom); Hv = 8'($urandom);
        Label = 2'($urandom);
        Clear = 1'($urandom); Fin = 1'($urandom);
        e_ready = 1'b0; e_drop8 = d8; e_drop2 = d2;
        step();
        if (!d8) begin hist[l][cnt[l]] = v; cnt[l]++; end
        if (!d2) begin hist[2+l][cnt[2+l]] = v; cnt[2+l]++; end
        quiet();
    endtask

    task automatic clear();
        quiet();
        Clear = 1'b1; ValidIn = 1'b1; Fin = 1'($urandom);
        Hv = 8'($urandom); Label = 2'($urandom);
        e_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        quiet();
    endtask

    task automatic finalize(input int stall);
        int k;
        quiet();
        Fin = 1'b1; ValidIn = 1'($urandom);
        e_ready = 1'b0;
        step();
        for (int c = 0; c < 2; c++) begin
            Fin = 1'($urandom); Clear = 1'($urandom);
            ValidIn = 1'($urandom); ReadyIn = 1'($urandom);
            e_ready = 1'b0; e_valid = 1'b0;
            step();
            e_valid = 1'b1; e_lbl = 2'(c);
            e_hv8 = maj(c); e_hv2 = maj(2 + c);
            k = (stall < 0) ? $urandom_range(0, 3) : stall;
            repeat (k) begin
                ReadyIn = 1'b0;
                Fin = 1'($urandom); Clear = 1'($urandom);
                step();
            end
            ReadyIn = 1'b1;
            em8[c] = hvo8; em2[c] = hvo2;
            step();
        end
        quiet();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        quiet();
        #3;
        check("rst_ready", 32'(rdy8), 32'd0);
        check("rst_valid", 32'(vld8), 32'd0);
        check("rst_drop", 32'(drp8), 32'd0);
        check("rst_hv", 32'(hvo8), 32'd0);
        check("rst_lbl", 32'(lbo2), 32'd0);
        repeat (2) step();
        Reset_RI = 1'b1;
        chk = 1'b1;
        idle(2);

        finalize(1);
        check("t1_p0", 32'(em8[0]), 32'h00);
        check("t1_p1", 32'(em8[1]), 32'h00);

        send(8'hC0, 2'd0); send(8'hA0, 2'd0); send(8'h81, 2'd0);
        finalize(0);
        check("t2_p0", 32'(em8[0]), 32'h80);
        check("t2_p1", 32'(em8[1]), 32'h00);

        send(8'hF0, 2'd1); send(8'h0F, 2'd1);
        finalize(2);
        check("t3_tie", 32'(em8[1]), 32'h00);
        send(8'hF0, 2'd1);
        finalize(5);
        check("t3_p1", 32'(em8[1]), 32'hF0);
        check("t3_p1_c2", 32'(em2[1]), 32'hF0);

        send(8'hFF, 2'd2); send(8'h55, 2'd3);
        finalize(0);
        check("t5_p0", 32'(em8[0]), 32'h80);
        check("t5_p1", 32'(em8[1]), 32'hF0);

        clear();
        repeat (4) send(8'h01, 2'd0);
        send(8'hFE, 2'd0); send(8'hFE, 2'd0);
        finalize(1);
        check("t5_sat8", 32'(em8[0]), 32'h01);
        check("t5_sat2", 32'(em2[0]), 32'h01);

        clear();
        finalize(0);
        check("t6_p0", 32'(em8[0]), 32'h00);
        check("t6_p1", 32'(em2[1]), 32'h00);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 39);
            if (r < 30) begin
                if ($urandom_range(0, 9) < 8)
                    send(8'($urandom), 2'($urandom_range(0, 1)));
                else
                    send(8'($urandom), 2'($urandom_range(2, 3)));
            end else if (r < 36) finalize(-1);
            else if (r < 39) idle($urandom_range(1, 3));
            else clear();
        end

        send(8'hFF, 2'd0); send(8'hFF, 2'd1);
        quiet();
        Fin = 1'b1; e_ready = 1'b0;
        step();
        Fin = 1'b0; e_valid = 1'b0;
        step();
        chk = 1'b0;
        #1;
        check("mid_valid", 32'(vld8), 32'd1);
        Reset_RI = 1'b0;
        #1;
        check("arst_valid8", 32'(vld8), 32'd0);
        check("arst_valid2", 32'(vld2), 32'd0);
        check("arst_ready", 32'(rdy8), 32'd0);
        check("arst_hv", 32'(hvo8), 32'd0);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        step();
        Reset_RI = 1'b1;
        quiet();
        chk = 1'b1;
        idle(4);
        finalize(1);
        check("post_p0", 32'(em8[0]), 32'h00);
        check("post_p1", 32'(em8[1]), 32'h00);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
